regfile_sb: RTL and testbench

Parametrised register file with a write-back scoreboard for the MIPS datapath. It provides DEPTH registers of DATA_W bits, two combinational read ports with write-through bypass, and one write port. Per-register busy bits track in-flight destination writes so the decode stage can detect RAW/WAW hazards and stall. It sits between decode (read and issue) and write-back (write and busy clear).

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_sb_if.sv | 35 +++
 rtl/regfile_rd_port.sv | 33 +++
 rtl/regfile_sb.sv | 99 +++++++++
 tb/tb_regfile_sb.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizing constants for the regfile_sb register file and scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

    typedef logic [DATA_W_DEF-1:0] reg_word_t;

    // A busy count must hold DEPTH itself, hence one bit more than the address.
    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/write-back bus of the register file: write port, two read ports, issue port and scoreboard view.
interface regfile_sb_if import regfile_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = cnt_width(ADDR_W);

    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rd1_busy;
    logic              rd2_busy;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              iss_ready;
    logic              iss_err;
    logic [DEPTH-1:0]  busy;
    logic [CNT_W-1:0]  busy_cnt;

    modport master (
        output we, wa, wd, ra1, ra2, iss_en, iss_addr,
        input  rd1, rd2, rd1_busy, rd2_busy, iss_ready, iss_err, busy, busy_cnt
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, iss_en, iss_addr,
        output rd1, rd2, rd1_busy, rd2_busy, iss_ready, iss_err, busy, busy_cnt
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: storage mux, same-cycle write bypass and busy lookup.
// With ZERO_REG_EN defined, address 0 always reads as zero and never reports busy.
module regfile_rd_port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs_i,
    input  logic [2**ADDR_W-1:0]             busy_i,
    input  logic                             we_i,
    input  logic [ADDR_W-1:0]                wa_i,
    input  logic [DATA_W-1:0]                wd_i,
    input  logic [ADDR_W-1:0]                ra_i,
    output logic [DATA_W-1:0]                rd_o,
    output logic                             rd_busy_o
);

    always_comb begin
        rd_o      = regs_i[ra_i];
        rd_busy_o = busy_i[ra_i];
        // A write-back landing this cycle both supplies the data and resolves the hazard.
        if (we_i && (wa_i == ra_i)) begin
            rd_o      = wd_i;
            rd_busy_o = 1'b0;
        end
`ifdef ZERO_REG_EN
        if (ra_i == '0) begin
            rd_o      = '0;
            rd_busy_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register write-back scoreboard for RAW/WAW hazard detection.
// Define ZERO_REG_EN to hardwire register 0 to zero (MIPS $zero).
module regfile_sb import regfile_pkg::*; #(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_sb_if.slave   bus
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = cnt_width(ADDR_W);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         err_q, err_d;

    logic we_eff;
    logic iss_ready;
    logic iss_set;
    logic cnt_inc;
    logic cnt_dec;

    always_comb begin
        we_eff    = bus.we;
        iss_ready = ~busy_q[bus.iss_addr] | (bus.we && (bus.wa == bus.iss_addr));
        iss_set   = bus.iss_en & iss_ready;
`ifdef ZERO_REG_EN
        if (bus.wa == '0) begin
            we_eff = 1'b0;
        end
        if (bus.iss_addr == '0) begin
            iss_ready = 1'b1;
            iss_set   = 1'b0;
        end
`endif
        // Count moves only when a bit actually flips, so it tracks popcount through collisions.
        cnt_inc = iss_set & ~busy_q[bus.iss_addr];
        cnt_dec = we_eff & busy_q[bus.wa] & ~(iss_set && (bus.iss_addr == bus.wa));

        busy_d = busy_q;
        if (we_eff) begin
            busy_d[bus.wa] = 1'b0;
        end
        if (iss_set) begin
            busy_d[bus.iss_addr] = 1'b1;
        end

        cnt_d = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
        err_d = err_q | (bus.iss_en & ~iss_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= {DEPTH{RESET_VAL}};
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (we_eff) begin
                regs_q[bus.wa] <= bus.wd;
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
        .regs_i    (regs_q),
        .busy_i    (busy_q),
        .we_i      (bus.we),
        .wa_i      (bus.wa),
        .wd_i      (bus.wd),
        .ra_i      (bus.ra1),
        .rd_o      (bus.rd1),
        .rd_busy_o (bus.rd1_busy)
    );

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
        .regs_i    (regs_q),
        .busy_i    (busy_q),
        .we_i      (bus.we),
        .wa_i      (bus.wa),
        .wd_i      (bus.wd),
        .ra_i      (bus.ra2),
        .rd_o      (bus.rd2),
        .rd_busy_o (bus.rd2_busy)
    );

    assign bus.iss_ready = iss_ready;
    assign bus.iss_err   = err_q;
    assign bus.busy      = busy_q;
    assign bus.busy_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against a behavioural register/scoreboard model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int              DW    = DATA_W_DEF;
    localparam int              AW    = ADDR_W_DEF;
    localparam int              DEPTH = 2**AW;
    localparam logic [DW-1:0]   RV    = 8'h5A;
`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .RESET_VAL(RV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    reg_word_t m_reg [DEPTH];
    bit        m_busy[DEPTH];
    bit        m_err;
    int        n_chk = 0;
    int        n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
        if (ZR && ra == 0) return '0;
        if (bus.we && bus.wa == ra) return bus.wd;
        return m_reg[ra];
    endfunction

    function automatic logic exp_rbusy(input logic [AW-1:0] ra);
        if (ZR && ra == 0) return 1'b0;
        return m_busy[ra] && !(bus.we && bus.wa == ra);
    endfunction

    function automatic logic exp_ready();
        if (ZR && bus.iss_addr == 0) return 1'b1;
        return !m_busy[bus.iss_addr] || (bus.we && bus.wa == bus.iss_addr);
    endfunction

    function automatic logic [DEPTH-1:0] exp_busy_vec();
        logic [DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic check_all();
        chk("rd1",       32'(bus.rd1),       32'(exp_rd(bus.ra1)));
        chk("rd2",       32'(bus.rd2),       32'(exp_rd(bus.ra2)));
        chk("rd1_busy",  32'(bus.rd1_busy),  32'(exp_rbusy(bus.ra1)));
        chk("rd2_busy",  32'(bus.rd2_busy),  32'(exp_rbusy(bus.ra2)));
        chk("iss_ready", 32'(bus.iss_ready), 32'(exp_ready()));
        chk("busy",      32'(bus.busy),      32'(exp_busy_vec()));
        chk("busy_cnt",  32'(bus.busy_cnt),  32'(exp_cnt()));
        chk("iss_err",   32'(bus.iss_err),   32'(m_err));
    endtask

    // Apply the rules for one clock edge to the model, using the inputs currently driven.
    task automatic model_update();
        logic rdy;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_reg[i]  = RV;
                m_busy[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            rdy = exp_ready();
            if (bus.we && !(ZR && bus.wa == 0)) begin
                m_reg[bus.wa]  = bus.wd;
                m_busy[bus.wa] = 1'b0;
            end
            if (bus.iss_en) begin
                if (rdy) begin
                    if (!(ZR && bus.iss_addr == 0)) m_busy[bus.iss_addr] = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic ie, input logic [AW-1:0] ia);
        @(negedge clk);
        rst_n        = r;
        bus.we       = w;
        bus.wa       = a;
        bus.wd       = d;
        bus.ra1      = r1;
        bus.ra2      = r2;
        bus.iss_en   = ie;
        bus.iss_addr = ia;
        #1;
        check_all();
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        drive(1'b1, 1'b0, '0, '0, r1, r2, 1'b0, r2);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.ra1 = '0; bus.ra2 = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0;
        model_update();
        @(posedge clk);

        // Reset then read every address.
        drive(1'b0, 1'b1, 3'd2, 8'hEE, '0, '0, 1'b1, 3'd6);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            idle(AW'(i), AW'(DEPTH - 1 - i));
            chk("rst_rd1", 32'(bus.rd1), (ZR && i == 0) ? 32'd0 : 32'(RV));
            chk("rst_cnt", 32'(bus.busy_cnt), 32'd0);
            tick();
        end

        // Write with same-cycle bypass, then read back from storage.
        drive(1'b1, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd0, 1'b0, 3'd0);
        chk("byp_rd1", 32'(bus.rd1), 32'hA5);
        tick();
        idle(3'd3, 3'd0);
        chk("stor_rd1", 32'(bus.rd1), 32'hA5);
        tick();

        // Scoreboard set on issue, cleared by write-back.
        drive(1'b1, 1'b0, '0, '0, 3'd0, 3'd0, 1'b1, 3'd5);
        tick();
        idle(3'd0, 3'd5);
        chk("sb_busy5", 32'(bus.busy[5]), 32'd1);
        chk("sb_cnt1", 32'(bus.busy_cnt), 32'd1);
        chk("sb_rd2busy", 32'(bus.rd2_busy), 32'd1);
        chk("sb_ready5", 32'(bus.iss_ready), 32'd0);
        tick();
        drive(1'b1, 1'b1, 3'd5, 8'h3C, 3'd0, 3'd5, 1'b0, 3'd5);
        chk("wb_rd2", 32'(bus.rd2), 32'h3C);
        chk("wb_rd2busy", 32'(bus.rd2_busy), 32'd0);
        tick();
        idle(3'd0, 3'd5);
        chk("wb_cnt0", 32'(bus.busy_cnt), 32'd0);
        tick();

        // Same-address write/issue collision, then a rejected issue.
        drive(1'b1, 1'b0, '0, '0, 3'd0, 3'd0, 1'b1, 3'd2);
        tick();
        drive(1'b1, 1'b1, 3'd2, 8'h11, 3'd2, 3'd0, 1'b1, 3'd2);
        chk("col_ready", 32'(bus.iss_ready), 32'd1);
        tick();
        idle(3'd2, 3'd0);
        chk("col_busy2", 32'(bus.busy[2]), 32'd1);
        chk("col_cnt", 32'(bus.busy_cnt), 32'd1);
        chk("col_rd1", 32'(bus.rd1), 32'h11);
        tick();
        drive(1'b1, 1'b0, '0, '0, 3'd0, 3'd0, 1'b1, 3'd4);
        tick();
        drive(1'b1, 1'b0, '0, '0, 3'd0, 3'd0, 1'b1, 3'd4);
        chk("rej_ready", 32'(bus.iss_ready), 32'd0);
        tick();
        idle(3'd0, 3'd0);
        chk("err_set", 32'(bus.iss_err), 32'd1);
        tick();
        idle(3'd0, 3'd0);
        chk("err_sticky", 32'(bus.iss_err), 32'd1);
        tick();

        // Reset in the middle of in-flight writes.
        drive(1'b0, 1'b0, '0, '0, 3'd0, 3'd0, 1'b0, 3'd0);
        tick();
        for (int i = 4; i < 8; i++) begin
            drive(1'b1, 1'b0, '0, '0, 3'd0, 3'd0, 1'b1, AW'(i));
            tick();
        end
        idle(3'd0, 3'd0);
        chk("mid_busy", 32'(bus.busy), 32'hF0);
        tick();
        drive(1'b0, 1'b1, 3'd1, 8'h77, 3'd1, 3'd0, 1'b1, 3'd2);
        tick();
        idle(3'd1, 3'd0);
        chk("mid_busy0", 32'(bus.busy), 32'd0);
        chk("mid_cnt0", 32'(bus.busy_cnt), 32'd0);
        chk("mid_rd1", 32'(bus.rd1), 32'(RV));
        tick();

`ifdef ZERO_REG_EN
        drive(1'b1, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b1, 3'd0);
        chk("z_rd1", 32'(bus.rd1), 32'd0);
        chk("z_ready", 32'(bus.iss_ready), 32'd1);
        tick();
        idle(3'd0, 3'd0);
        chk("z_busy0", 32'(bus.busy[0]), 32'd0);
        chk("z_rd1_st", 32'(bus.rd1), 32'd0);
        tick();
`endif

        // Randomized traffic, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            drive(logic'(($urandom % 64) != 0), logic'($urandom % 2), AW'($urandom), DW'($urandom),
                  AW'($urandom), AW'($urandom), logic'(($urandom % 3) != 0), AW'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
